// File: rtl/mem_stage_if.sv
// Data-memory request/grant/rvalid port of the memory-access stage.
// master: the pipeline stage (drives request, write, address, byte enables, write data).
// slave:  the data memory (returns grant, read-valid and read data).
interface mem_stage_if;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_gnt_i;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;

  modport master (
    output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
    input  dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
  );

  modport slave (
    input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
    output dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
  );
endinterface

// File: rtl/mem_stage.sv
// RV32 memory-access stage: branch/jump/return redirect, load/store over the dmem port, MEM/WB register.
// Latency: non-access and granted stores commit at the next edge; loads commit at the edge ending the rvalid cycle.
// Backpressure: stall_o holds upstream while a request is ungranted or load data is outstanding.
// Ports: clk_i/rst_ni; EX/MEM inputs (valid_i, controls, funct3_i, EQ_i, datapath words, rd_i);
//        dmem (mem_stage_if.master); stall_o/flush_o/PCsrc_o/PCtarget_o; MEM/WB register outputs.
module mem_stage (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        valid_i,
  input  logic        RegWrite_i,
  input  logic        MemWrite_i,
  input  logic        Branch_i,
  input  logic        Jump_i,
  input  logic        Ret_i,
  input  logic [1:0]  WriteSrc_i,
  input  logic [2:0]  funct3_i,
  input  logic        EQ_i,
  input  logic [31:0] ALUout_i,
  input  logic [31:0] ImmOp_i,
  input  logic [31:0] pcPlus4_i,
  input  logic [31:0] pcPlusImm_i,
  input  logic [31:0] regOp2_i,
  input  logic [4:0]  rd_i,
  mem_stage_if.master dmem,
  output logic        stall_o,
  output logic        flush_o,
  output logic [1:0]  PCsrc_o,
  output logic [31:0] PCtarget_o,
  output logic        RegWrite_o,
  output logic [1:0]  WriteSrc_o,
  output logic [4:0]  rd_o,
  output logic [31:0] ALUout_o,
  output logic [31:0] ReadData_o,
  output logic [31:0] ImmOp_o,
  output logic [31:0] pcPlus4_o
);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t      state;
  logic        load;
  logic        store;
  logic        access;
  logic        commit;
  logic [1:0]  off;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] load_ext;

  assign load   = valid_i & RegWrite_i & (WriteSrc_i == 2'b01);
  assign store  = valid_i & MemWrite_i;
  assign access = load | store;
  assign off    = ALUout_i[1:0];

  // Anything that is not a memory access commits immediately (including
  // invalid entries, which land in MEM/WB with RegWrite cleared).
  assign commit = ~access
                | ((state == S_IDLE) & store & dmem.dmem_gnt_i)
                | ((state == S_WAIT) & dmem.dmem_rvalid_i);

  assign stall_o = access & ~commit;

  // Request only from IDLE; since inputs are frozen during a stall, address,
  // be and wdata stay constant until the grant arrives.
  assign dmem.dmem_req_o   = (state == S_IDLE) & access;
  assign dmem.dmem_we_o    = store;
  assign dmem.dmem_addr_o  = {ALUout_i[31:2], 2'b00};
  assign dmem.dmem_be_o    = be;
  assign dmem.dmem_wdata_o = wdata;

  // Store lane selection; loads (and anything else) use the full word.
  always_comb begin
    be    = 4'b1111;
    wdata = regOp2_i;
    if (store) begin
      case (funct3_i)
        3'b000: begin
          be    = 4'b0001 << off;
          wdata = {4{regOp2_i[7:0]}};
        end
        3'b001: begin
          be    = off[1] ? 4'b1100 : 4'b0011;
          wdata = {2{regOp2_i[15:0]}};
        end
        default: begin
          be    = 4'b1111;
          wdata = regOp2_i;
        end
      endcase
    end
  end

  // Load data extraction and extension.
  always_comb begin
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    byte_sel = 8'h00;
    half_sel = 16'h0000;
    case (off)
      2'b00:   byte_sel = dmem.dmem_rdata_i[7:0];
      2'b01:   byte_sel = dmem.dmem_rdata_i[15:8];
      2'b10:   byte_sel = dmem.dmem_rdata_i[23:16];
      default: byte_sel = dmem.dmem_rdata_i[31:24];
    endcase
    half_sel = off[1] ? dmem.dmem_rdata_i[31:16] : dmem.dmem_rdata_i[15:0];
    case (funct3_i)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_ext = {24'h000000, byte_sel};
      3'b101:  load_ext = {16'h0000, half_sel};
      default: load_ext = dmem.dmem_rdata_i;
    endcase
  end

  // Redirect: return has priority over jump/branch.
  always_comb begin
    PCsrc_o    = 2'b00;
    PCtarget_o = pcPlus4_i;
    if (valid_i) begin
      if (Ret_i) begin
        PCsrc_o    = 2'b10;
        PCtarget_o = ALUout_i & ~32'h1;
      end else if (Jump_i ||
                   (Branch_i && (((funct3_i == 3'b000) && EQ_i) ||
                                 ((funct3_i == 3'b001) && !EQ_i)))) begin
        PCsrc_o    = 2'b01;
        PCtarget_o = pcPlusImm_i;
      end
    end
  end

  assign flush_o = (PCsrc_o != 2'b00);

  // Access FSM. rvalid seen in IDLE is ignored; a reset while in WAIT
  // abandons the outstanding load.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (load && dmem.dmem_gnt_i) state <= S_WAIT;
        S_WAIT:  if (dmem.dmem_rvalid_i)      state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // MEM/WB register: loads on commit, otherwise inserts a bubble by
  // clearing RegWrite while the datapath fields hold.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      RegWrite_o <= 1'b0;
      WriteSrc_o <= 2'b00;
      rd_o       <= 5'd0;
      ALUout_o   <= 32'h0;
      ReadData_o <= 32'h0;
      ImmOp_o    <= 32'h0;
      pcPlus4_o  <= 32'h0;
    end else if (commit) begin
      RegWrite_o <= RegWrite_i & valid_i;
      WriteSrc_o <= WriteSrc_i;
      rd_o       <= rd_i;
      ALUout_o   <= ALUout_i;
      ReadData_o <= load_ext;
      ImmOp_o    <= ImmOp_i;
      pcPlus4_o  <= pcPlus4_i;
    end else begin
      RegWrite_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: redirect and store-lane vector tables, hand-written
// multi-cycle sequences, and randomized transactions against a reference model.
module tb_mem_stage;

  logic clk = 1'b0;
  logic rst_ni;
  logic valid, reg_write, mem_write, branch, jump, ret, eq;
  logic [1:0]  write_src;
  logic [2:0]  funct3;
  logic [31:0] alu, imm, pc4, pcimm, op2;
  logic [4:0]  rd;
  logic        stall, flush;
  logic [1:0]  pc_src;
  logic [31:0] pc_tgt;
  logic        rw_o;
  logic [1:0]  ws_o;
  logic [4:0]  rd_o;
  logic [31:0] alu_o, rdata_o, imm_o, pc4_o;

  int n_tests = 0;
  int n_fail  = 0;

  mem_stage_if dmem_bus ();

  mem_stage dut (
    .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid),
    .RegWrite_i(reg_write), .MemWrite_i(mem_write), .Branch_i(branch),
    .Jump_i(jump), .Ret_i(ret), .WriteSrc_i(write_src), .funct3_i(funct3),
    .EQ_i(eq), .ALUout_i(alu), .ImmOp_i(imm), .pcPlus4_i(pc4),
    .pcPlusImm_i(pcimm), .regOp2_i(op2), .rd_i(rd), .dmem(dmem_bus),
    .stall_o(stall), .flush_o(flush), .PCsrc_o(pc_src), .PCtarget_o(pc_tgt),
    .RegWrite_o(rw_o), .WriteSrc_o(ws_o), .rd_o(rd_o), .ALUout_o(alu_o),
    .ReadData_o(rdata_o), .ImmOp_o(imm_o), .pcPlus4_o(pc4_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic v, br, jmp, rt;
    logic [2:0] f3;
    logic e;
    logic [31:0] a;
    logic [1:0] exp_src;
    logic [31:0] exp_tgt;
  } redir_vec_t;

  typedef struct {
    logic [2:0] f3;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0] exp_be;
    logic [31:0] exp_wd;
  } store_vec_t;

  redir_vec_t rvec [9];
  store_vec_t svec [6];
  logic [2:0] ld_f3s [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid = 0; reg_write = 0; mem_write = 0; branch = 0; jump = 0; ret = 0;
    eq = 0; write_src = 2'b00; funct3 = 3'b000; alu = 0; imm = 0; pc4 = 0;
    pcimm = 0; op2 = 0; rd = 0;
    dmem_bus.dmem_gnt_i = 0; dmem_bus.dmem_rvalid_i = 0; dmem_bus.dmem_rdata_i = 0;
  endtask

  // Reference: load data extraction by shifting/masking the word.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] o, input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * o)) & 32'hFF;
    h = (w >> (16 * o[1])) & 32'hFFFF;
    case (f3)
      3'd0:    return b[7]  ? (b | 32'hFFFFFF00) : b;
      3'd1:    return h[15] ? (h | 32'hFFFF0000) : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  // Reference: store lanes from access size, naturally aligned start lane.
  function automatic void ref_store(input logic [2:0] f3, input logic [1:0] o, input logic [31:0] d,
                                    output logic [3:0] be, output logic [31:0] wd);
    int nb, start;
    logic [31:0] m;
    nb = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    start = int'(o) - (int'(o) % nb);
    be = 4'(((1 << nb) - 1) << start);
    m = (nb == 4) ? 32'hFFFFFFFF : ((32'h1 << (8 * nb)) - 1);
    wd = (d & m) * ((nb == 1) ? 32'h01010101 : (nb == 2) ? 32'h00010001 : 32'h1);
  endfunction

  // Drives one access (or non-access) through its handshake. gd: cycle of
  // grant; rdl: cycles from grant to rvalid for loads. Checks stall/req each
  // cycle and the bubble in MEM/WB after every stalled edge.
  task automatic run_cycles(input string tag, input bit acc, input bit ld, input int gd,
                            input int rdl, input bit noise, input bit chk_lane,
                            input logic [3:0] ebe, input logic [31:0] ewd,
                            input logic [31:0] eaddr, input logic [31:0] rword);
    int ccyc;
    ccyc = !acc ? 0 : (ld ? gd + rdl : gd);
    for (int c = 0; c <= ccyc; c++) begin
      dmem_bus.dmem_gnt_i    = acc && (c == gd);
      dmem_bus.dmem_rvalid_i = (ld && (c == gd + rdl)) ||
                               (noise && (!ld || c <= gd) && ($urandom_range(0, 1) == 1));
      dmem_bus.dmem_rdata_i  = (ld && (c == gd + rdl)) ? rword : $urandom;
      #3;
      chk({tag, " stall"}, 32'(stall), 32'(c < ccyc));
      chk({tag, " req"}, 32'(dmem_bus.dmem_req_o), 32'(acc && c <= gd));
      if (chk_lane && c <= gd) begin
        chk({tag, " be"}, 32'(dmem_bus.dmem_be_o), 32'(ebe));
        chk({tag, " addr"}, dmem_bus.dmem_addr_o, eaddr);
        chk({tag, " we"}, 32'(dmem_bus.dmem_we_o), 32'(!ld));
        if (!ld) chk({tag, " wdata"}, dmem_bus.dmem_wdata_o, ewd);
      end
      tick();
      if (c < ccyc) chk({tag, " bubble"}, 32'(rw_o), 32'd0);
    end
    dmem_bus.dmem_gnt_i = 0;
    dmem_bus.dmem_rvalid_i = 0;
  endtask

  task automatic chk_wb(input string tag, input logic erw, input logic [1:0] ews, input logic [4:0] erd,
                        input logic [31:0] ealu, input logic [31:0] eimm, input logic [31:0] epc4);
    chk({tag, " RegWrite_o"}, 32'(rw_o), 32'(erw));
    chk({tag, " WriteSrc_o"}, 32'(ws_o), 32'(ews));
    chk({tag, " rd_o"}, 32'(rd_o), 32'(erd));
    chk({tag, " ALUout_o"}, alu_o, ealu);
    chk({tag, " ImmOp_o"}, imm_o, eimm);
    chk({tag, " pcPlus4_o"}, pc4_o, epc4);
  endtask

  initial begin
    rvec[0] = '{1, 1, 0, 0, 3'b001, 0, 32'h0, 2'b01, 32'h40};      // BNE taken
    rvec[1] = '{1, 1, 0, 0, 3'b000, 0, 32'h0, 2'b00, 32'h1004};    // BEQ not taken
    rvec[2] = '{1, 1, 0, 0, 3'b000, 1, 32'h0, 2'b01, 32'h40};      // BEQ taken
    rvec[3] = '{1, 1, 0, 0, 3'b001, 1, 32'h0, 2'b00, 32'h1004};    // BNE not taken
    rvec[4] = '{1, 0, 1, 0, 3'b000, 0, 32'h0, 2'b01, 32'h40};      // jump
    rvec[5] = '{1, 0, 0, 1, 3'b000, 0, 32'h81, 2'b10, 32'h80};     // return
    rvec[6] = '{1, 0, 1, 1, 3'b000, 0, 32'h2003, 2'b10, 32'h2002}; // return beats jump
    rvec[7] = '{0, 0, 1, 0, 3'b000, 0, 32'h0, 2'b00, 32'h1004};    // invalid jump
    rvec[8] = '{1, 1, 0, 0, 3'b100, 1, 32'h0, 2'b00, 32'h1004};    // other branch type

    svec[0] = '{3'b010, 32'h100, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF};
    svec[1] = '{3'b000, 32'h103, 32'h12345678, 4'b1000, 32'h78787878};
    svec[2] = '{3'b000, 32'h101, 32'h000000AB, 4'b0010, 32'hABABABAB};
    svec[3] = '{3'b001, 32'h102, 32'h0000BEEF, 4'b1100, 32'hBEEFBEEF};
    svec[4] = '{3'b001, 32'h200, 32'h1234CAFE, 4'b0011, 32'hCAFECAFE};
    svec[5] = '{3'b000, 32'h000, 32'h11223344, 4'b0001, 32'h44444444};

    ld_f3s[0] = 3'd0; ld_f3s[1] = 3'd1; ld_f3s[2] = 3'd2;
    ld_f3s[3] = 3'd4; ld_f3s[4] = 3'd5; ld_f3s[5] = 3'd6;

    // Reset state
    idle_inputs();
    rst_ni = 0;
    repeat (3) tick();
    chk_wb("reset", 0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0);
    chk("reset ReadData_o", rdata_o, 32'h0);
    chk("reset req", 32'(dmem_bus.dmem_req_o), 32'd0);
    chk("reset stall", 32'(stall), 32'd0);
    rst_ni = 1;
    tick();

    // Redirect table
    pc4 = 32'h1004; pcimm = 32'h40;
    foreach (rvec[i]) begin
      valid = rvec[i].v; branch = rvec[i].br; jump = rvec[i].jmp; ret = rvec[i].rt;
      funct3 = rvec[i].f3; eq = rvec[i].e; alu = rvec[i].a;
      #3;
      chk($sformatf("redir%0d PCsrc", i), 32'(pc_src), 32'(rvec[i].exp_src));
      chk($sformatf("redir%0d target", i), pc_tgt, rvec[i].exp_tgt);
      chk($sformatf("redir%0d flush", i), 32'(flush), 32'(rvec[i].exp_src != 2'b00));
      chk($sformatf("redir%0d stall", i), 32'(stall), 32'd0);
      tick();
    end
    idle_inputs();

    // Store lane table, granted in the same cycle
    foreach (svec[i]) begin
      valid = 1; mem_write = 1; funct3 = svec[i].f3; alu = svec[i].a; op2 = svec[i].d;
      run_cycles($sformatf("store%0d", i), 1, 0, 0, 0, 0, 1, svec[i].exp_be, svec[i].exp_wd,
                 {svec[i].a[31:2], 2'b00}, 32'h0);
      chk($sformatf("store%0d RegWrite_o", i), 32'(rw_o), 32'd0);
    end

    // SB with grant two cycles late: request held steady while stalled
    valid = 1; mem_write = 1; funct3 = 3'b000; alu = 32'h103; op2 = 32'h12345678;
    run_cycles("sb_gnt2", 1, 0, 2, 0, 0, 1, 4'b1000, 32'h78787878, 32'h100, 32'h0);
    idle_inputs();

    // LB / LBU with rvalid three cycles after grant
    valid = 1; reg_write = 1; write_src = 2'b01; funct3 = 3'b000; alu = 32'h101; rd = 5'd7;
    imm = 32'h11; pc4 = 32'h2004;
    run_cycles("lb", 1, 1, 0, 3, 0, 1, 4'b1111, 32'h0, 32'h100, 32'h0000F000);
    chk("lb ReadData_o", rdata_o, 32'hFFFFFFF0);
    chk_wb("lb", 1, 2'b01, 5'd7, 32'h101, 32'h11, 32'h2004);
    funct3 = 3'b100;
    run_cycles("lbu", 1, 1, 0, 3, 0, 1, 4'b1111, 32'h0, 32'h100, 32'h0000F000);
    chk("lbu ReadData_o", rdata_o, 32'h000000F0);

    // Reset while waiting for load data, then a spurious rvalid
    funct3 = 3'b010; alu = 32'h10;
    dmem_bus.dmem_gnt_i = 1;
    tick();
    dmem_bus.dmem_gnt_i = 0;
    #2;
    rst_ni = 0;
    #1;
    chk("rst_wait RegWrite_o", 32'(rw_o), 32'd0);
    chk("rst_wait ReadData_o", rdata_o, 32'h0);
    tick();
    rst_ni = 1;
    dmem_bus.dmem_rvalid_i = 1; dmem_bus.dmem_rdata_i = 32'hCAFEF00D;
    #3;
    chk("rst_wait req after release", 32'(dmem_bus.dmem_req_o), 32'd1);
    chk("rst_wait stall after release", 32'(stall), 32'd1);
    tick();
    chk_wb("rst_wait", 0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0);
    chk("rst_wait ReadData_o after rvalid", rdata_o, 32'h0);
    idle_inputs();
    valid = 1; mem_write = 1; funct3 = 3'b010; alu = 32'h40; op2 = 32'h5;
    run_cycles("rst_wait idle store", 1, 0, 0, 0, 0, 1, 4'b1111, 32'h5, 32'h40, 32'h0);
    idle_inputs();

    // Randomized transactions against the reference model
    for (int t = 0; t < 150; t++) begin
      int kind, gd, rdl;
      logic [3:0] ebe;
      logic [31:0] ewd, word;
      string tag;
      tag = $sformatf("rnd%0d", t);
      kind = $urandom_range(0, 2);
      alu = $urandom; imm = $urandom; pc4 = $urandom; pcimm = $urandom; op2 = $urandom;
      rd = 5'($urandom); branch = 0; jump = 0; ret = 0; eq = 0;
      gd = $urandom_range(0, 2); rdl = $urandom_range(1, 3);
      word = $urandom;
      if (kind == 0) begin
        valid = 1'($urandom); reg_write = 1'($urandom); mem_write = 0;
        funct3 = 3'($urandom);
        case ($urandom_range(0, 2))
          0: write_src = 2'b00;
          1: write_src = 2'b10;
          default: write_src = 2'b11;
        endcase
        run_cycles(tag, 0, 0, 0, 0, 1, 0, 4'h0, 32'h0, 32'h0, 32'h0);
        chk_wb(tag, valid & reg_write, write_src, rd, alu, imm, pc4);
      end else if (kind == 1) begin
        valid = 1; reg_write = 0; mem_write = 1; write_src = 2'($urandom);
        funct3 = 3'($urandom_range(0, 2));
        ref_store(funct3, alu[1:0], op2, ebe, ewd);
        run_cycles(tag, 1, 0, gd, 0, 1, 1, ebe, ewd, alu & 32'hFFFFFFFC, 32'h0);
        chk_wb(tag, 0, write_src, rd, alu, imm, pc4);
      end else begin
        valid = 1; reg_write = 1; mem_write = 0; write_src = 2'b01;
        funct3 = ld_f3s[$urandom_range(0, 5)];
        run_cycles(tag, 1, 1, gd, rdl, 1, 1, 4'b1111, 32'h0, alu & 32'hFFFFFFFC, word);
        chk_wb(tag, 1, 2'b01, rd, alu, imm, pc4);
        chk({tag, " ReadData_o"}, rdata_o, ref_load(funct3, alu[1:0], word));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
